// File: rtl/fsk_modulator_if.sv
// Byte handshake between an upstream source and the FSK modulator.
//   data_in    : byte offered by the source
//   data_valid : source has a byte
//   data_ready : modulator accepts a byte this cycle
interface fsk_modulator_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/fsk_modulator.sv
// Framed binary FSK modulator: start bit, 8 data bits LSB first, stop bit,
// each held BAUD_DIV cycles as a phase-continuous mark/space square wave.
//   clk_in    : 5 MHz clock from the divider
//   reset     : synchronous, active-high
//   bus       : byte handshake (slave side)
//   fsk_out   : modulated square wave
//   bit_out   : symbol currently being sent
//   tx_active : high while a frame is in progress
module fsk_modulator #(
  parameter int unsigned BAUD_DIV   = 5000,
  parameter int unsigned MARK_HALF  = 1250,
  parameter int unsigned SPACE_HALF = 2500
) (
  input  logic             clk_in,
  input  logic             reset,
  fsk_modulator_if.slave   bus,
  output logic             fsk_out,
  output logic             bit_out,
  output logic             tx_active
);

  localparam int unsigned BAUD_W   = $clog2(BAUD_DIV);
  localparam int unsigned TONE_MAX = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
  localparam int unsigned TONE_W   = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [TONE_W-1:0] MARK_LAST  = TONE_W'(MARK_HALF - 1);
  localparam logic [TONE_W-1:0] SPACE_LAST = TONE_W'(SPACE_HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [TONE_W-1:0]  tone_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         data_q;
  logic               data_ready_q;

  logic               baud_end_c;
  logic               tone_end_c;
  logic [TONE_W-1:0]  half_last_c;

  assign bus.data_ready = data_ready_q;

  // Tone half-period follows the symbol currently on bit_out.
  always_comb begin
    half_last_c = bit_out ? MARK_LAST : SPACE_LAST;
    baud_end_c  = (baud_cnt == BAUD_LAST);
    tone_end_c  = (tone_cnt == half_last_c);
  end

  // Frame sequencer, baud timing and tone generation.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      tone_cnt     <= '0;
      bit_idx      <= '0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      fsk_out      <= 1'b0;
      bit_out      <= 1'b0;
      tx_active    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_ready_q <= 1'b1;
          tx_active    <= 1'b0;
          fsk_out      <= 1'b0;
          bit_out      <= 1'b0;
          if (bus.data_valid && data_ready_q) begin
            data_q       <= bus.data_in;
            baud_cnt     <= '0;
            tone_cnt     <= '0;
            bit_idx      <= '0;
            data_ready_q <= 1'b0;
            tx_active    <= 1'b1;
            state        <= START;
          end
        end
        default: begin
          if (baud_end_c) begin
            // Bit boundary: restart tone phase, hold fsk_out level.
            baud_cnt <= '0;
            tone_cnt <= '0;
            if (state == START) begin
              state   <= DATA;
              bit_idx <= '0;
              bit_out <= data_q[0];
            end else if (state == DATA) begin
              if (bit_idx == 3'd7) begin
                state   <= STOP;
                bit_out <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                bit_out <= data_q[bit_idx + 3'd1];
              end
            end else begin
              state        <= IDLE;
              tx_active    <= 1'b0;
              data_ready_q <= 1'b1;
              fsk_out      <= 1'b0;
              bit_out      <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
            if (tone_end_c) begin
              tone_cnt <= '0;
              fsk_out  <= ~fsk_out;
            end else begin
              tone_cnt <= tone_cnt + TONE_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_modulator.sv
module tb_fsk_modulator;

  localparam int BAUD = 20;
  localparam int MH   = 2;
  localparam int SH   = 5;
  localparam int FRM  = 10 * BAUD;

  logic clk;
  logic reset;
  logic fsk_out, bit_out, tx_active;

  fsk_modulator_if bus ();

  fsk_modulator #(.BAUD_DIV(BAUD), .MARK_HALF(MH), .SPACE_HALF(SH)) dut (
    .clk_in   (clk),
    .reset    (reset),
    .bus      (bus),
    .fsk_out  (fsk_out),
    .bit_out  (bit_out),
    .tx_active(tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic bit_a [0:409];
  logic fsk_a [0:409];
  logic tx_a  [0:409];
  logic rdy_a [0:409];

  typedef struct {
    int   cyc;
    logic bit_e;
    logic fsk_e;
    logic tx_e;
    logic rdy_e;
  } vec_t;

  vec_t vecs [0:21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic b, input logic f,
                            input logic t, input logic r);
    check({name, ".bit_out"}, -1, bit_out, b);
    check({name, ".fsk_out"}, -1, fsk_out, f);
    check({name, ".tx_active"}, -1, tx_active, t);
    check({name, ".data_ready"}, -1, bus.data_ready, r);
  endtask

  // Record n cycles starting at the current one; data_valid is high with
  // pv_data for cycles [pv_at, pv_at+pv_len) and low otherwise.
  task automatic capture(input int n, input int pv_at, input int pv_len, input logic [7:0] pv_data);
    for (int k = 0; k < n; k++) begin
      bit_a[k] = bit_out;
      fsk_a[k] = fsk_out;
      tx_a[k]  = tx_active;
      rdy_a[k] = bus.data_ready;
      if (k >= pv_at && k < pv_at + pv_len) begin
        bus.data_valid = 1'b1;
        bus.data_in    = pv_data;
      end else begin
        bus.data_valid = 1'b0;
      end
      if (k < n - 1) tick();
    end
  endtask

  function automatic logic sym(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Expected frame: symbol per baud slot, and a tone that toggles every
  // 'half' cycles measured from the start of each bit, never on offset 0.
  task automatic check_frame(input string name, input int off, input logic [7:0] b);
    logic lvl;
    lvl = 1'b0;
    for (int k = 0; k < FRM; k++) begin
      int   slot, ofs, h;
      logic s;
      slot = k / BAUD;
      ofs  = k % BAUD;
      s    = sym(b, slot);
      h    = s ? MH : SH;
      if (ofs != 0 && (ofs % h) == 0) lvl = ~lvl;
      check({name, ".bit"}, off + k, bit_a[off+k], s);
      check({name, ".fsk"}, off + k, fsk_a[off+k], lvl);
      check({name, ".tx"},  off + k, tx_a[off+k], 1'b1);
      check({name, ".rdy"}, off + k, rdy_a[off+k], 1'b0);
    end
    check({name, ".end_fsk"}, off + FRM, fsk_a[off+FRM], 1'b0);
    check({name, ".end_bit"}, off + FRM, bit_a[off+FRM], 1'b0);
    check({name, ".end_tx"},  off + FRM, tx_a[off+FRM], 1'b0);
    check({name, ".end_rdy"}, off + FRM, rdy_a[off+FRM], 1'b1);
  endtask

  initial begin
    // Hand-computed waveform points for 0xA5 (cycle 0 = first START cycle).
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{5,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{9,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{10,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{15,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{19,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{20,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{22,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{24,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{39,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{40,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{45,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{100, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{105, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{120, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{122, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{160, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{180, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{182, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{199, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{200, 1'b0, 1'b0, 1'b0, 1'b1};

    reset          = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single byte 0xA5.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hA5;
    tick();
    capture(FRM + 1, 0, 0, 8'h00);
    for (int i = 0; i < 22; i++) begin
      check("a5_vec.bit", vecs[i].cyc, bit_a[vecs[i].cyc], vecs[i].bit_e);
      check("a5_vec.fsk", vecs[i].cyc, fsk_a[vecs[i].cyc], vecs[i].fsk_e);
      check("a5_vec.tx",  vecs[i].cyc, tx_a[vecs[i].cyc],  vecs[i].tx_e);
      check("a5_vec.rdy", vecs[i].cyc, rdy_a[vecs[i].cyc], vecs[i].rdy_e);
    end
    check_frame("a5", 0, 8'hA5);

    // Back-to-back 0x00 then 0xFF with data_valid held high.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h00;
    tick();
    capture(2 * FRM + 2, 0, 300, 8'hFF);
    check("b2b.gap_tx", FRM, tx_a[FRM], 1'b0);
    check("b2b.start2", FRM + 1, tx_a[FRM+1], 1'b1);
    check_frame("b2b_00", 0, 8'h00);
    check_frame("b2b_ff", FRM + 1, 8'hFF);

    // Busy ignore: 0xFF offered mid-frame must not disturb 0x3C.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h3C;
    tick();
    capture(FRM + 1, 50, 3, 8'hFF);
    check_frame("busy_3c", 0, 8'h3C);

    // Mid-frame reset during data bit 4 of 0x5A.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h5A;
    tick();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 109; i++) tick();
    check("mid.in_bit4_tx", 109, tx_active, 1'b1);
    check("mid.in_bit4_bit", 109, bit_out, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("mid_release", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("mid_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hC3;
    tick();
    capture(FRM + 1, 0, 0, 8'h00);
    check_frame("after_c3", 0, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
